mem_stage: RTL and testbench

//  Memory/write-back stage; the receiving end of the ALU result interface. Samples the ALU's

---
 rtl/mem_stage.sv | 218 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage
//   Memory / write-back stage. Waits for the ALU's level ready, captures the
//   result bundle and performs one of four operations decoded from {m,w}:
//   flag-only update (00), register write (01), store (10) or load (11).
//   Loads and stores use an internal word RAM with a registered read.
//   Each completed operation is acknowledged by toggling triggerOut.
//
// Ports
//   clk, reset      stage clock, asynchronous active-high reset
//   readyIn         ALU ready level (asynchronous to clk, synchronised here)
//   dataIn1         register-write result
//   dataIn2         load address or store data
//   cpsrIn          CPSR value from the ALU
//   srcDstIn        [3:0] destination register; store address for stores
//   w, m            write-register / memory-operation flags
//   triggerOut      toggles once per acknowledged operation
//   regWrEn/Addr/Data  register-file write port (one-cycle strobe)
//   cpsrWrEn/cpsrOut   CPSR write strobe and held CPSR value
//   busy            high while the FSM is anywhere but IDLE
//   addrErr         sticky out-of-range load/store address flag
//   opCount         completed operations, wrapping

module mem_stage #(
  parameter int RAM_DEPTH   = 256,
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        readyIn,
  input  logic [31:0] dataIn1,
  input  logic [31:0] dataIn2,
  input  logic [31:0] cpsrIn,
  input  logic [31:0] srcDstIn,
  input  logic        w,
  input  logic        m,
  output logic        triggerOut,
  output logic        regWrEn,
  output logic [3:0]  regWrAddr,
  output logic [31:0] regWrData,
  output logic        cpsrWrEn,
  output logic [31:0] cpsrOut,
  output logic        busy,
  output logic        addrErr,
  output logic [15:0] opCount
);

  typedef enum logic [2:0] {
    WAIT_LOW = 3'd0,
    IDLE     = 3'd1,
    EXEC     = 3'd2,
    LOAD_WB  = 3'd3,
    ACK      = 3'd4
  } state_t;

  state_t stateReg, stateNext;

  // Synchroniser for readyIn. syncValidReg fills with ones behind it so that
  // the zeros left in the chain by reset are not mistaken for a real low
  // level; otherwise a ready held high through reset would be re-captured.
  logic [SYNC_STAGES-1:0] syncReg;
  logic [SYNC_STAGES-1:0] syncValidReg;
  logic                   rdyS;
  logic                   chainFull;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      syncReg      <= '0;
      syncValidReg <= '0;
    end else begin
      syncReg      <= {syncReg[SYNC_STAGES-2:0], readyIn};
      syncValidReg <= {syncValidReg[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rdyS      = syncReg[SYNC_STAGES-1];
  assign chainFull = syncValidReg[SYNC_STAGES-1];

  // Captured bundle; stable from IDLE until the next capture.
  logic [31:0] dataIn1Reg, dataIn2Reg, cpsrInReg, srcDstReg;
  logic        wReg, mReg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataIn1Reg <= '0;
      dataIn2Reg <= '0;
      cpsrInReg  <= '0;
      srcDstReg  <= '0;
      wReg       <= 1'b0;
      mReg       <= 1'b0;
    end else if (stateReg == IDLE && rdyS) begin
      dataIn1Reg <= dataIn1;
      dataIn2Reg <= dataIn2;
      cpsrInReg  <= cpsrIn;
      srcDstReg  <= srcDstIn;
      wReg       <= w;
      mReg       <= m;
    end
  end

  // Any address bit above the RAM index range marks the access as bad.
  logic loadAddrBad, storeAddrBad;
  assign loadAddrBad  = |dataIn2Reg[31:ADDR_W];
  assign storeAddrBad = |srcDstReg[31:ADDR_W];

  // Data RAM: no reset, registered read.
  logic [31:0] ram [RAM_DEPTH];
  logic [31:0] ramRdData;
  logic        ramWe, ramRe;

  always_ff @(posedge clk) begin
    if (ramWe)
      ram[srcDstReg[ADDR_W-1:0]] <= dataIn2Reg;
    if (ramRe)
      ramRdData <= ram[dataIn2Reg[ADDR_W-1:0]];
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stateReg <= WAIT_LOW;
    else       stateReg <= stateNext;
  end

  // FSM next-state logic
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      WAIT_LOW: if (chainFull && !rdyS) stateNext = IDLE;
      IDLE:     if (rdyS) stateNext = EXEC;
      EXEC:     stateNext = (mReg && wReg) ? LOAD_WB : ACK;
      LOAD_WB:  stateNext = ACK;
      ACK:      stateNext = WAIT_LOW;
      default:  stateNext = WAIT_LOW;
    endcase
  end

  // FSM output logic: next values for the registered outputs plus RAM strobes.
  logic        regWrEnNext, cpsrWrEnNext, triggerNext, addrErrNext;
  logic [3:0]  regWrAddrNext;
  logic [31:0] regWrDataNext, cpsrOutNext;
  logic [15:0] opCountNext;

  always_comb begin
    regWrEnNext   = 1'b0;
    regWrAddrNext = regWrAddr;
    regWrDataNext = regWrData;
    cpsrWrEnNext  = 1'b0;
    cpsrOutNext   = cpsrOut;
    triggerNext   = triggerOut;
    addrErrNext   = addrErr;
    opCountNext   = opCount;
    ramWe         = 1'b0;
    ramRe         = 1'b0;
    case (stateReg)
      EXEC: begin
        case ({mReg, wReg})
          2'b00: begin
            cpsrWrEnNext = 1'b1;
            cpsrOutNext  = cpsrInReg;
          end
          2'b01: begin
            regWrEnNext   = 1'b1;
            regWrAddrNext = srcDstReg[3:0];
            regWrDataNext = dataIn1Reg;
            cpsrWrEnNext  = 1'b1;
            cpsrOutNext   = cpsrInReg;
          end
          2'b11: begin
            ramRe = !loadAddrBad;
            if (loadAddrBad) addrErrNext = 1'b1;
          end
          default: begin
            ramWe = !storeAddrBad;
            if (storeAddrBad) addrErrNext = 1'b1;
          end
        endcase
      end
      LOAD_WB: begin
        // A suppressed load still writes back, with zero data.
        regWrEnNext   = 1'b1;
        regWrAddrNext = srcDstReg[3:0];
        regWrDataNext = loadAddrBad ? 32'h0 : ramRdData;
      end
      ACK: begin
        triggerNext = ~triggerOut;
        opCountNext = opCount + 16'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regWrEn    <= 1'b0;
      regWrAddr  <= '0;
      regWrData  <= '0;
      cpsrWrEn   <= 1'b0;
      cpsrOut    <= '0;
      triggerOut <= 1'b0;
      addrErr    <= 1'b0;
      opCount    <= '0;
      busy       <= 1'b0;
    end else begin
      regWrEn    <= regWrEnNext;
      regWrAddr  <= regWrAddrNext;
      regWrData  <= regWrDataNext;
      cpsrWrEn   <= cpsrWrEnNext;
      cpsrOut    <= cpsrOutNext;
      triggerOut <= triggerNext;
      addrErr    <= addrErrNext;
      opCount    <= opCountNext;
      // Registered from the next state so busy tracks the state exactly and
      // still reads 0 straight out of reset.
      busy       <= (stateNext != IDLE);
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        readyIn;
  logic [31:0] dataIn1, dataIn2, cpsrIn, srcDstIn;
  logic        wIn, mIn;
  logic        triggerOut, regWrEn, cpsrWrEn, busy, addrErr;
  logic [3:0]  regWrAddr;
  logic [31:0] regWrData, cpsrOut;
  logic [15:0] opCount;

  mem_stage #(.RAM_DEPTH(256), .ADDR_W(8), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .readyIn(readyIn),
    .dataIn1(dataIn1), .dataIn2(dataIn2), .cpsrIn(cpsrIn), .srcDstIn(srcDstIn),
    .w(wIn), .m(mIn),
    .triggerOut(triggerOut), .regWrEn(regWrEn), .regWrAddr(regWrAddr),
    .regWrData(regWrData), .cpsrWrEn(cpsrWrEn), .cpsrOut(cpsrOut),
    .busy(busy), .addrErr(addrErr), .opCount(opCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mMem [256];
  bit          mValid [256];
  logic [31:0] mCpsr;
  bit          mErr;
  logic [15:0] mCount;
  logic        mTrig;

  // Observations from the last operation
  int          oRegPulses, oCpsrPulses, oToggles, oLat, oBusyHigh;
  logic [3:0]  oRegAddr;
  logic [31:0] oRegData;

  task automatic modelReset();
    mCpsr  = '0;
    mErr   = 1'b0;
    mCount = '0;
    mTrig  = 1'b0;
  endtask

  // Drives one ALU handoff, observes every cycle, then compares to the model.
  task automatic execOp(input string tag, input logic m, input logic w,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] cp, input logic [31:0] sd, input int hold);
    logic trigPrev;
    bit isLoad, isStore, badLoad, badStore, expReg, known;
    logic [31:0] expData;
    int expLat, highCycles;
    highCycles = 14 + hold;
    @(negedge clk);
    dataIn1 = d1; dataIn2 = d2; cpsrIn = cp; srcDstIn = sd; mIn = m; wIn = w;
    readyIn = 1'b1;
    oRegPulses = 0; oCpsrPulses = 0; oToggles = 0; oLat = -1; oBusyHigh = 0;
    oRegAddr = 'x; oRegData = 'x;
    trigPrev = triggerOut;
    for (int cyc = 1; cyc <= highCycles + 6; cyc++) begin
      @(negedge clk);
      if (regWrEn) begin oRegPulses++; oRegAddr = regWrAddr; oRegData = regWrData; end
      if (cpsrWrEn) oCpsrPulses++;
      if (busy) oBusyHigh++;
      if (triggerOut !== trigPrev) begin
        oToggles++;
        if (oLat < 0) oLat = cyc;
        trigPrev = triggerOut;
      end
      if (cyc == highCycles) readyIn = 1'b0;
    end

    // Expected behaviour from the operation rules
    isLoad   = m && w;
    isStore  = m && !w;
    badLoad  = isLoad && (d2 >= 32'd256);
    badStore = isStore && (sd >= 32'd256);
    expReg   = (!m && w) || isLoad;
    known    = 1'b1;
    expData  = '0;
    if (!m && w) expData = d1;
    else if (isLoad && !badLoad) begin
      known   = mValid[d2[7:0]];
      expData = mMem[d2[7:0]];
    end
    if (!m) mCpsr = cp;
    if (badLoad || badStore) mErr = 1'b1;
    if (isStore && !badStore) begin mMem[sd[7:0]] = d2; mValid[sd[7:0]] = 1'b1; end
    mCount = mCount + 16'd1;
    mTrig  = ~mTrig;
    expLat = SYNC + 1 + (isLoad ? 3 : 2);

    $display("op %s m=%0d w=%0d d1=%h d2=%h cpsr=%h sd=%h -> lat=%0d toggles=%0d reg=%0d/%h/%h cpsrWr=%0d cnt=%0d err=%0d",
             tag, m, w, d1, d2, cp, sd, oLat, oToggles, oRegPulses, oRegAddr, oRegData,
             oCpsrPulses, opCount, addrErr);

    checks++; if (oToggles !== 1) begin errors++; $display("FAIL %s toggles: got %0d expected 1", tag, oToggles); end
    checks++; if (oLat !== expLat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", tag, oLat, expLat); end
    checks++; if (oRegPulses !== int'(expReg)) begin errors++; $display("FAIL %s regWrEn pulses: got %0d expected %0d", tag, oRegPulses, expReg); end
    if (expReg) begin
      checks++; if (oRegAddr !== sd[3:0]) begin errors++; $display("FAIL %s regWrAddr: got %h expected %h", tag, oRegAddr, sd[3:0]); end
      if (known) begin
        checks++; if (oRegData !== expData) begin errors++; $display("FAIL %s regWrData: got %h expected %h", tag, oRegData, expData); end
      end
    end
    checks++; if (oCpsrPulses !== int'(!m)) begin errors++; $display("FAIL %s cpsrWrEn pulses: got %0d expected %0d", tag, oCpsrPulses, !m); end
    checks++; if (cpsrOut !== mCpsr) begin errors++; $display("FAIL %s cpsrOut: got %h expected %h", tag, cpsrOut, mCpsr); end
    checks++; if (addrErr !== mErr) begin errors++; $display("FAIL %s addrErr: got %0d expected %0d", tag, addrErr, mErr); end
    checks++; if (opCount !== mCount) begin errors++; $display("FAIL %s opCount: got %0d expected %0d", tag, opCount, mCount); end
    checks++; if (triggerOut !== mTrig) begin errors++; $display("FAIL %s triggerOut: got %0d expected %0d", tag, triggerOut, mTrig); end
    checks++; if (busy !== 1'b0 || oBusyHigh == 0) begin errors++; $display("FAIL %s busy: got end=%0d highCycles=%0d expected end=0 highCycles>0", tag, busy, oBusyHigh); end
  endtask

  task automatic test_reset();
    reset = 1'b1; readyIn = 1'b0; mIn = 0; wIn = 0;
    dataIn1 = '0; dataIn2 = '0; cpsrIn = '0; srcDstIn = '0;
    modelReset();
    repeat (3) @(negedge clk);
    checks++;
    if ({triggerOut, regWrEn, regWrAddr, regWrData, cpsrWrEn, cpsrOut, busy, addrErr, opCount} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got trig=%0d regEn=%0d addr=%h data=%h cpsrEn=%0d cpsr=%h busy=%0d err=%0d cnt=%0d expected all 0",
               triggerOut, regWrEn, regWrAddr, regWrData, cpsrWrEn, cpsrOut, busy, addrErr, opCount);
    end
    reset = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset idle busy: got %0d expected 0", busy); end
    $display("reset done");
  endtask

  task automatic test_regwrite();
    execOp("T1_regwrite", 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0, 32'h4000_0000, 32'd5, 0);
    checks++; if (oRegData !== 32'hDEAD_BEEF || oRegAddr !== 4'd5 || cpsrOut !== 32'h4000_0000 || opCount !== 16'd1) begin
      errors++;
      $display("FAIL T1 constants: got addr=%h data=%h cpsr=%h cnt=%0d expected 5/DEADBEEF/40000000/1", oRegAddr, oRegData, cpsrOut, opCount);
    end
  endtask

  task automatic test_store_load();
    execOp("T2_store", 1'b1, 1'b0, 32'h0, 32'h1234_5678, 32'h0, 32'h10, 0);
    execOp("T2_load", 1'b1, 1'b1, 32'h0, 32'h10, 32'h0, 32'd3, 0);
    checks++; if (oRegData !== 32'h1234_5678 || oRegAddr !== 4'd3) begin
      errors++; $display("FAIL T2 load data: got %h/%h expected 3/12345678", oRegAddr, oRegData);
    end
  endtask

  task automatic test_flag_only();
    execOp("T3_flag", 1'b0, 1'b0, 32'h5555_AAAA, 32'h0, 32'h2000_0000, 32'd9, 0);
    checks++; if (oRegPulses !== 0 || oCpsrPulses !== 1 || cpsrOut !== 32'h2000_0000) begin
      errors++; $display("FAIL T3 flag-only: got reg=%0d cpsrWr=%0d cpsr=%h expected 0/1/20000000", oRegPulses, oCpsrPulses, cpsrOut);
    end
  endtask

  task automatic test_bad_addr();
    execOp("T4_badload", 1'b1, 1'b1, 32'h0, 32'h0000_0100, 32'h0, 32'd4, 0);
    checks++; if (addrErr !== 1'b1 || oRegData !== 32'h0) begin
      errors++; $display("FAIL T4 bad load: got err=%0d data=%h expected 1/0", addrErr, oRegData);
    end
    execOp("T4_badstore", 1'b1, 1'b0, 32'h0, 32'hCAFE_F00D, 32'h0, 32'h110, 0);
    execOp("T4_reload", 1'b1, 1'b1, 32'h0, 32'h10, 32'h0, 32'd6, 0);
    execOp("T4_goodop", 1'b0, 1'b1, 32'h0BAD_C0DE, 32'h0, 32'h8000_0000, 32'd2, 0);
    checks++; if (addrErr !== 1'b1) begin errors++; $display("FAIL T4 sticky: got %0d expected 1", addrErr); end
  endtask

  task automatic test_ready_held();
    execOp("T5_held", 1'b0, 1'b1, 32'h1111_2222, 32'h0, 32'h1000_0000, 32'd7, 20);
    execOp("T5_again", 1'b0, 1'b1, 32'h3333_4444, 32'h0, 32'h3000_0000, 32'd8, 0);
  endtask

  task automatic test_random();
    logic m, w;
    logic [31:0] d1, d2, cp, sd;
    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom_range(0, 1)); w = 1'($urandom_range(0, 1));
      d1 = $urandom; cp = $urandom; d2 = $urandom; sd = $urandom;
      if (m) begin
        if (w) d2 = ($urandom_range(0, 7) == 0) ? (32'h100 << $urandom_range(0, 23)) : 32'($urandom_range(0, 31));
        else   sd = ($urandom_range(0, 7) == 0) ? (32'h100 << $urandom_range(0, 23)) : 32'($urandom_range(0, 31));
      end
      execOp($sformatf("rand%0d", i), m, w, d1, d2, cp, sd, 0);
    end
  endtask

  task automatic test_reset_midop();
    int regSeen = 0, trigSeen = 0;
    @(negedge clk);
    dataIn1 = '0; dataIn2 = 32'h10; cpsrIn = '0; srcDstIn = 32'd7; mIn = 1; wIn = 1;
    readyIn = 1'b1;
    repeat (4) @(negedge clk);   // capture, EXEC, now in LOAD_WB
    reset = 1'b1;
    modelReset();
    #1;
    checks++; if (triggerOut !== 1'b0 || opCount !== 16'd0 || regWrEn !== 1'b0) begin
      errors++; $display("FAIL T6 in reset: got trig=%0d cnt=%0d regEn=%0d expected 0/0/0", triggerOut, opCount, regWrEn);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      if (regWrEn || cpsrWrEn) regSeen++;
      if (triggerOut !== 1'b0 || opCount !== 16'd0) trigSeen++;
    end
    $display("T6 after reset with ready high: strobes=%0d ackCycles=%0d busy=%0d", regSeen, trigSeen, busy);
    checks++; if (regSeen !== 0) begin errors++; $display("FAIL T6 strobes: got %0d expected 0", regSeen); end
    checks++; if (trigSeen !== 0) begin errors++; $display("FAIL T6 no capture: got %0d ack cycles expected 0", trigSeen); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL T6 waiting busy: got %0d expected 1", busy); end
    readyIn = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL T6 idle after low: got busy=%0d expected 0", busy); end
    execOp("T6_recover", 1'b0, 1'b1, 32'h7777_8888, 32'h0, 32'h6000_0000, 32'd1, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mValid[i] = 1'b0;
    test_reset();
    test_regwrite();
    test_store_load();
    test_flag_only();
    test_bad_addr();
    test_ready_held();
    test_random();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
